// File: rtl/change_dispenser.sv
// Coin hopper payout controller: pays a change amount greedily (2-unit coins, then 1-unit)
// using a strobe/ack handshake per coin. Define HOPPER_LOW_EN to add the tube2_empty input.
module change_dispenser #(
    parameter int AMT_W       = 4,
    parameter int PULSE_CYC   = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             hopper_ack,
`ifdef HOPPER_LOW_EN
    input  logic             tube2_empty,
`endif
    output logic             eject_1,
    output logic             eject_2,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);

    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, EJECT, WAIT_ACK, DONE, FAULT} state_t;

    state_t           state;
    logic [PW-1:0]    pulse_cnt;
    logic [WW-1:0]    wait_cnt;
    logic             coin_two;
    logic             acked;
    logic             no_two;
    logic             ack_now;
    logic             start_two;
    logic [AMT_W-1:0] coin_val;
    logic [AMT_W-1:0] paid;
    logic [AMT_W-1:0] rem_after;
    logic [AMT_W-1:0] start_val;

`ifdef HOPPER_LOW_EN
    assign no_two = tube2_empty;
`else
    assign no_two = 1'b0;
`endif

    // Only the first ack of a coin slot counts; the next coin is chosen from the owed balance.
    assign coin_val  = coin_two ? AMT_W'(2) : AMT_W'(1);
    assign paid      = remaining - coin_val;
    assign ack_now   = hopper_ack && !acked && (state == EJECT || state == WAIT_ACK);
    assign rem_after = ack_now ? paid : remaining;
    assign start_val = (state == IDLE) ? amount : rem_after;
    assign start_two = (start_val >= AMT_W'(2)) && !no_two;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            wait_cnt  <= '0;
            coin_two  <= 1'b0;
            acked     <= 1'b0;
            eject_1   <= 1'b0;
            eject_2   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (amount != '0) begin
                            state     <= EJECT;
                            busy      <= 1'b1;
                            remaining <= amount;
                            coin_two  <= start_two;
                            eject_2   <= start_two;
                            eject_1   <= !start_two;
                            pulse_cnt <= PW'(1);
                            acked     <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                EJECT: begin
                    if (ack_now) begin
                        remaining <= paid;
                        acked     <= 1'b1;
                    end
                    if (pulse_cnt != PULSE_LAST) begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end else if (!(acked || ack_now)) begin
                        state    <= WAIT_ACK;
                        eject_1  <= 1'b0;
                        eject_2  <= 1'b0;
                        wait_cnt <= WW'(1);
                    end else if (rem_after == '0) begin
                        state   <= DONE;
                        eject_1 <= 1'b0;
                        eject_2 <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        coin_two  <= start_two;
                        eject_2   <= start_two;
                        eject_1   <= !start_two;
                        pulse_cnt <= PW'(1);
                        acked     <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    if (ack_now) begin
                        remaining <= paid;
                        if (paid == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= EJECT;
                            coin_two  <= start_two;
                            eject_2   <= start_two;
                            eject_1   <= !start_two;
                            pulse_cnt <= PW'(1);
                            acked     <= 1'b0;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= FAULT;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a timeline model predicts every output on every cycle
// of a payout from the coin/ack schedule, and each cycle is compared against the DUT.
module tb_change_dispenser;

    localparam int AMT_W = 4;
    localparam int P     = 2;
    localparam int T     = 15;
    localparam int MAXC  = 512;

    logic             clk = 1'b0;
    logic             reset;
    logic             req;
    logic [AMT_W-1:0] amount;
    logic             hopper_ack;
    logic             tube2_empty;
    logic             eject_1;
    logic             eject_2;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remaining;

    int vectors     = 0;
    int miscompares = 0;

    bit xe1[MAXC], xe2[MAXC], xbusy[MAXC], xdone[MAXC], xfault[MAXC];
    int xrem[MAXC];
    bit ackv[MAXC], reqv[MAXC];
    int ack_off[32];
    int trace_len;
    int quiet_end;

    always #5 clk = ~clk;

    change_dispenser #(.AMT_W(AMT_W), .PULSE_CYC(P), .ACK_TIMEOUT(T)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .amount(amount),
        .hopper_ack(hopper_ack),
`ifdef HOPPER_LOW_EN
        .tube2_empty(tube2_empty),
`endif
        .eject_1(eject_1),
        .eject_2(eject_2),
        .busy(busy),
        .done(done),
        .fault(fault),
        .remaining(remaining)
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%03h expected 0x%03h (e1 e2 busy done fault rem[3:0])", tag, got, exp);
        end
    endtask

    function automatic int packDut();
        logic [8:0] v;
        v = {eject_1, eject_2, busy, done, fault, remaining};
        return int'(v);
    endfunction

    function automatic int packExp(input int c);
        logic [8:0] v;
        v = {xe1[c], xe2[c], xbusy[c], xdone[c], xfault[c], AMT_W'(xrem[c])};
        return int'(v);
    endfunction

    // mode 0: random ack offsets, 1: ack one cycle after each strobe, 2: first coin never acked
    task automatic setOffsets(input int mode);
        for (int i = 0; i < 32; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (mode == 1) ack_off[i] = P;
            else if (mode == 2) ack_off[i] = -1;
            else if (r <= 3) ack_off[i] = int'($urandom_range(0, P - 1));
            else if (r <= 7) ack_off[i] = int'($urandom_range(P, P + 3));
            else if (r == 8) ack_off[i] = P + T - 1;
            else ack_off[i] = ($urandom_range(0, 3) == 0) ? -1 : P;
        end
    endtask

    // Timeline model: cycle 0 carries the req; strobes start on cycle 1.
    task automatic buildTrace(input int amt, input bit t2e, input bit extras);
        int owed, t, n, o, a, nxt, val;
        bit two;
        for (int c = 0; c < MAXC; c++) begin
            xe1[c] = 0; xe2[c] = 0; xbusy[c] = 0; xdone[c] = 0; xfault[c] = 0;
            xrem[c] = 0; ackv[c] = 0; reqv[c] = 0;
        end
        if (extras) ackv[0] = 1'($urandom_range(0, 1));
        if (amt == 0) begin
            xdone[1]  = 1;
            quiet_end = 1;
            trace_len = 4;
        end else begin
            owed = amt;
            t    = 1;
            n    = 0;
            forever begin
                two = (owed >= 2) && !t2e;
                val = two ? 2 : 1;
                o   = ack_off[n];
                n++;
                for (int c = 0; c < P; c++) begin
                    xe2[t + c] = two;
                    xe1[t + c] = !two;
                end
                if (o < 0) begin
                    for (int c = t; c < t + P + T; c++) begin
                        xbusy[c] = 1;
                        xrem[c]  = owed;
                    end
                    trace_len = t + P + T + 3;
                    for (int c = t + P + T; c < trace_len; c++) begin
                        xfault[c] = 1;
                        xrem[c]   = owed;
                        if (extras) ackv[c] = 1'($urandom_range(0, 1));
                    end
                    quiet_end = trace_len - 1;
                    break;
                end
                a       = t + o;
                ackv[a] = 1;
                if (extras && o < P - 1) ackv[a + 1] = 1'($urandom_range(0, 1));
                nxt = (o < P) ? t + P : a + 1;
                for (int c = t; c < nxt; c++) begin
                    xbusy[c] = 1;
                    xrem[c]  = (c <= a) ? owed : owed - val;
                end
                owed -= val;
                t = nxt;
                if (owed == 0) begin
                    xdone[nxt] = 1;
                    quiet_end  = nxt;
                    trace_len  = nxt + 3;
                    if (extras) begin
                        ackv[nxt]     = 1'($urandom_range(0, 1));
                        ackv[nxt + 1] = 1'($urandom_range(0, 1));
                    end
                    break;
                end
            end
        end
        if (extras)
            for (int c = 1; c <= quiet_end; c++) reqv[c] = ($urandom_range(0, 3) == 0);
    endtask

    task automatic doReset();
        reset      = 1'b1;
        req        = 1'b0;
        hopper_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("reset_clear", packDut(), 0);
    endtask

    task automatic applyStimulus(input int amt, input bit t2e, input int reset_at, input bit extras);
        buildTrace(amt, t2e, extras);
        if (reset_at >= 0) begin
            for (int c = reset_at + 1; c < MAXC; c++) begin
                xe1[c] = 0; xe2[c] = 0; xbusy[c] = 0; xdone[c] = 0; xfault[c] = 0; xrem[c] = 0;
                reqv[c] = 0;
            end
            trace_len = reset_at + 4;
        end
        checkOutput($sformatf("amt%0d_idle", amt), packDut(), packExp(0));
        for (int c = 0; c < trace_len - 1; c++) begin
            req         = (c == 0) || reqv[c];
            amount      = (c == 0) ? AMT_W'(amt) : AMT_W'($urandom);
            hopper_ack  = ackv[c];
            reset       = (c == reset_at);
            tube2_empty = t2e;
            @(posedge clk); #1;
            checkOutput($sformatf("amt%0d_c%0d", amt, c + 1), packDut(), packExp(c + 1));
        end
        req        = 1'b0;
        hopper_ack = 1'b0;
        reset      = 1'b0;
        if (xfault[trace_len - 1]) doReset();
    endtask

    initial begin
        reset       = 1'b1;
        req         = 1'b0;
        hopper_ack  = 1'b0;
        amount      = '0;
        tube2_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", packDut(), 0);
        reset = 1'b0;

        setOffsets(1); applyStimulus(5, 1'b0, -1, 1'b0);
        setOffsets(1); applyStimulus(0, 1'b0, -1, 1'b1);
        setOffsets(2); applyStimulus(2, 1'b0, -1, 1'b0);
        setOffsets(1); applyStimulus(4, 1'b0, 4, 1'b0);
        setOffsets(1); applyStimulus(6, 1'b0, -1, 1'b1);
        setOffsets(1); applyStimulus(15, 1'b0, -1, 1'b0);
        setOffsets(0); applyStimulus(1, 1'b0, -1, 1'b1);
`ifdef HOPPER_LOW_EN
        setOffsets(1); applyStimulus(3, 1'b1, -1, 1'b0);
`endif
        for (int i = 0; i < 40; i++) begin
            bit t2e;
            t2e = 1'b0;
`ifdef HOPPER_LOW_EN
            t2e = 1'($urandom_range(0, 1));
`endif
            setOffsets(0);
            applyStimulus(int'($urandom_range(0, 15)), t2e, -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
